comparator_monitor: RTL and testbench
=====================================

COMPARATOR_MONITOR -- requirements
Module: comparator_monitor

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8, width of every event counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sample_en  input  1  qualifies the current comparator flags as one sample.
REQ-005 SHALL have port A_gt_B_reg  input  1  registered A>B flag from the upstream comparator.
REQ-006 SHALL have port A_eq_B_reg  input  1  registered A==B flag from the upstream comparator.
REQ-007 SHALL have port A_lt_B_reg  input  1  registered A<B flag from the upstream comparator.
REQ-008 SHALL have port clear  input  1  synchronous clear of counters, error flag and FSM.
REQ-009 SHALL have ports gt_count, eq_count, lt_count  output  CNT_WIDTH each  accepted-sample counts per class.
REQ-010 SHALL have port cross_up  output  1  one-cycle pulse on a completed LT->EQ->GT crossing.
REQ-011 SHALL have port cross_count  output  CNT_WIDTH  number of completed crossings.
REQ-012 SHALL have port onehot_err  output  1  sticky flag: a sample with non-one-hot flags was seen.

Function
REQ-013 A sample SHALL be taken at a rising clk edge where sample_en=1; flags are ignored when sample_en=0.
REQ-014 A sample SHALL be valid when exactly one of gt/eq/lt is 1 (decoding without the macro: REQ-030).
REQ-015 A valid sample SHALL increment its class counter by 1 at that edge; all outputs are registered, latency 1 clk.
REQ-016 Every counter SHALL saturate at 2^CNT_WIDTH-1; no wrap-around.
REQ-017 The FSM SHALL have states IDLE, SAW_LT and SAW_EQ, and SHALL change state only on a valid sample.
REQ-018 In IDLE: lt -> SAW_LT; eq or gt -> IDLE.
REQ-019 In SAW_LT: lt -> SAW_LT; eq -> SAW_EQ; gt -> IDLE with no crossing (a direct LT->GT is not a crossing).
REQ-020 In SAW_EQ: eq -> SAW_EQ; lt -> SAW_LT; gt -> IDLE, cross_up=1 for the cycle after that edge, and cross_count incremented (saturating).
REQ-021 cross_up SHALL be 0 in every other cycle; back-to-back crossings SHALL produce separate pulses.
REQ-022 clear=1 at an edge SHALL zero all counters, cross_up and onehot_err and force the FSM to IDLE; clear SHALL override a simultaneous sample.
REQ-023 An invalid sample (macro defined) SHALL leave all counters unchanged, set onehot_err, and force the FSM to IDLE.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, zero gt_count, eq_count, lt_count, cross_count, cross_up and onehot_err and force the FSM to IDLE.
REQ-025 rst asserted mid-sequence (FSM in SAW_LT or SAW_EQ) SHALL discard the partial crossing; no cross_up follows.
REQ-026 The first sample SHALL be taken at the first rising edge after rst deasserts.

Configuration
REQ-027 Macro COMPARATOR_MONITOR_ONEHOT_CHECK_EN SHALL compile the one-hot check in or out.
REQ-028 With the macro defined: behaviour per REQ-014 and REQ-023; onehot_err is sticky until rst or clear.
REQ-029 With the macro undefined: onehot_err SHALL be constant 0.
REQ-030 With the macro undefined, flags SHALL decode with priority gt > eq > lt, and an all-zero sample SHALL be ignored.

Verification
REQ-031 Reset: apply rst asynchronously between edges -> all outputs read 0 before the next edge; FSM in IDLE.
REQ-032 Sequence LT, EQ, EQ, GT (sample_en=1 each cycle) -> exactly one cross_up pulse one cycle after the GT edge; cross_count=1; lt=1, eq=2, gt=1.
REQ-033 Sequence LT, GT, then LT, EQ, LT, EQ, GT -> cross_up only after the final GT; cross_count=1; lt=3, eq=2, gt=2.
REQ-034 CNT_WIDTH=8 with 300 EQ samples -> eq_count holds 255; gt_count=0 and lt_count=0.
REQ-035 Macro defined: LT, then gt=1 with eq=1, then EQ, GT -> onehot_err=1; lt=1, eq=1, gt=1; no cross_up. Macro undefined: same stimulus -> onehot_err=0, gt=2, no cross_up.
REQ-036 Complete LT, EQ, then assert clear in the same cycle as a GT sample -> no cross_up; all counters and onehot_err read 0; FSM in IDLE.

Source files
------------

// File: rtl/comparator_monitor.sv
// Counts comparator flag classes, detects LT->EQ->GT crossings, flags non-one-hot samples (COMPARATOR_MONITOR_ONEHOT_CHECK_EN).
// Latency 1 clk on all outputs; no backpressure, a sample is taken on every enabled edge.
module comparator_monitor #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic                 A_gt_B_reg,
    input  logic                 A_eq_B_reg,
    input  logic                 A_lt_B_reg,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] gt_count,
    output logic [CNT_WIDTH-1:0] eq_count,
    output logic [CNT_WIDTH-1:0] lt_count,
    output logic                 cross_up,
    output logic [CNT_WIDTH-1:0] cross_count,
    output logic                 onehot_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAW_LT = 2'd1,
        SAW_EQ = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic [CNT_WIDTH-1:0] gt_count_q, gt_count_d;
    logic [CNT_WIDTH-1:0] eq_count_q, eq_count_d;
    logic [CNT_WIDTH-1:0] lt_count_q, lt_count_d;
    logic [CNT_WIDTH-1:0] cross_count_q, cross_count_d;
    logic                 cross_up_q, cross_up_d;
    logic                 onehot_err_q, onehot_err_d;

    logic is_gt, is_eq, is_lt, bad_smp;
    logic cross_fire;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    // Sample decode: strict one-hot when checking, otherwise priority gt > eq > lt.
    always_comb begin
        is_gt   = 1'b0;
        is_eq   = 1'b0;
        is_lt   = 1'b0;
        bad_smp = 1'b0;
        if (sample_en) begin
`ifdef COMPARATOR_MONITOR_ONEHOT_CHECK_EN
            case ({A_gt_B_reg, A_eq_B_reg, A_lt_B_reg})
                3'b100:  is_gt   = 1'b1;
                3'b010:  is_eq   = 1'b1;
                3'b001:  is_lt   = 1'b1;
                default: bad_smp = 1'b1;
            endcase
`else
            if (A_gt_B_reg)
                is_gt = 1'b1;
            else if (A_eq_B_reg)
                is_eq = 1'b1;
            else if (A_lt_B_reg)
                is_lt = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear || bad_smp) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (is_lt) state_d = SAW_LT;
                SAW_LT: begin
                    if (is_eq)      state_d = SAW_EQ;
                    else if (is_gt) state_d = IDLE;
                end
                SAW_EQ: begin
                    if (is_lt)      state_d = SAW_LT;
                    else if (is_gt) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cross_fire    = !clear && (state_q == SAW_EQ) && is_gt;
        gt_count_d    = gt_count_q;
        eq_count_d    = eq_count_q;
        lt_count_d    = lt_count_q;
        cross_count_d = cross_count_q;
        cross_up_d    = cross_fire;
        onehot_err_d  = onehot_err_q | bad_smp;
        if (clear) begin
            gt_count_d    = '0;
            eq_count_d    = '0;
            lt_count_d    = '0;
            cross_count_d = '0;
            onehot_err_d  = 1'b0;
        end else begin
            if (is_gt)      gt_count_d    = sat_inc(gt_count_q);
            if (is_eq)      eq_count_d    = sat_inc(eq_count_q);
            if (is_lt)      lt_count_d    = sat_inc(lt_count_q);
            if (cross_fire) cross_count_d = sat_inc(cross_count_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_count_q    <= '0;
            eq_count_q    <= '0;
            lt_count_q    <= '0;
            cross_count_q <= '0;
            cross_up_q    <= 1'b0;
            onehot_err_q  <= 1'b0;
        end else begin
            gt_count_q    <= gt_count_d;
            eq_count_q    <= eq_count_d;
            lt_count_q    <= lt_count_d;
            cross_count_q <= cross_count_d;
            cross_up_q    <= cross_up_d;
            onehot_err_q  <= onehot_err_d;
        end
    end

    assign gt_count    = gt_count_q;
    assign eq_count    = eq_count_q;
    assign lt_count    = lt_count_q;
    assign cross_count = cross_count_q;
    assign cross_up    = cross_up_q;
    assign onehot_err  = onehot_err_q;

endmodule

// File: tb/tb_comparator_monitor.sv
// Bench for comparator_monitor: directed sequences plus random traffic against a history-based model.
module tb_comparator_monitor;

    localparam int W    = 8;
    localparam int MAXC = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         sample_en, gt_in, eq_in, lt_in, clear;
    logic [W-1:0] gt_count, eq_count, lt_count, cross_count;
    logic         cross_up, onehot_err;

    int checks   = 0;
    int failures = 0;

    // Reference state: counts plus the list of accepted classes since the last GT/reset/clear/invalid.
    int m_gt, m_eq, m_lt, m_cr;
    bit m_up, m_err;
    int hist[$];  // 0 = LT, 1 = EQ, 2 = GT

    comparator_monitor #(.CNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en),
        .A_gt_B_reg(gt_in), .A_eq_B_reg(eq_in), .A_lt_B_reg(lt_in),
        .clear(clear),
        .gt_count(gt_count), .eq_count(eq_count), .lt_count(lt_count),
        .cross_up(cross_up), .cross_count(cross_count), .onehot_err(onehot_err)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".gt_count"},    32'(gt_count),    32'(m_gt));
        check({ctx, ".eq_count"},    32'(eq_count),    32'(m_eq));
        check({ctx, ".lt_count"},    32'(lt_count),    32'(m_lt));
        check({ctx, ".cross_count"}, 32'(cross_count), 32'(m_cr));
        check({ctx, ".cross_up"},    32'(cross_up),    32'(m_up));
        check({ctx, ".onehot_err"},  32'(onehot_err),  32'(m_err));
    endtask

    task automatic model_zero();
        m_gt = 0; m_eq = 0; m_lt = 0; m_cr = 0;
        m_up = 0; m_err = 0;
        hist.delete();
    endtask

    task automatic model_edge(input bit en, input bit g, input bit e, input bit l, input bit clr);
        int c;
        int k;
        int n;
        m_up = 0;
        c = -1;
        if (clr) begin
            model_zero();
            return;
        end
        if (!en) return;
`ifdef COMPARATOR_MONITOR_ONEHOT_CHECK_EN
        if (int'(g) + int'(e) + int'(l) != 1) begin
            m_err = 1;
            hist.delete();
            return;
        end
`endif
        if (g)      c = 2;
        else if (e) c = 1;
        else if (l) c = 0;
        if (c < 0) return;
        if (c == 0) begin
            m_lt = sat(m_lt);
            hist.push_back(0);
        end else if (c == 1) begin
            m_eq = sat(m_eq);
            hist.push_back(1);
        end else begin
            m_gt = sat(m_gt);
            // A crossing is GT preceded by one or more EQs that themselves follow an LT.
            k = hist.size();
            n = 0;
            while (k > 0 && hist[k-1] == 1) begin
                n++;
                k--;
            end
            if (n > 0 && k > 0 && hist[k-1] == 0) begin
                m_up = 1;
                m_cr = sat(m_cr);
            end
            hist.delete();
        end
    endtask

    task automatic step(input bit en, input bit g, input bit e, input bit l, input bit clr, input string ctx);
        @(negedge clk);
        sample_en = en; gt_in = g; eq_in = e; lt_in = l; clear = clr;
        @(posedge clk);
        model_edge(en, g, e, l, clr);
        #1;
        check_all(ctx);
    endtask

    // Class shortcut: 0 LT, 1 EQ, 2 GT, 3 GT+EQ together.
    task automatic smp(input int c, input string ctx);
        case (c)
            0:       step(1, 0, 0, 1, 0, ctx);
            1:       step(1, 0, 1, 0, 0, ctx);
            2:       step(1, 1, 0, 0, 0, ctx);
            default: step(1, 1, 1, 0, 0, ctx);
        endcase
    endtask

    // Reset raised between edges; outputs must be zero before the next edge.
    task automatic do_reset(input string ctx);
        @(negedge clk);
        sample_en = 0; gt_in = 0; eq_in = 0; lt_in = 0; clear = 0;
        #2 rst = 1'b1;
        model_zero();
        #1;
        check_all(ctx);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int f;
        bit g, e, l, en, clr;
        rst = 1'b1;
        sample_en = 0; gt_in = 0; eq_in = 0; lt_in = 0; clear = 0;
        model_zero();
        @(negedge clk);
        check_all("por");
        rst = 1'b0;

        // LT EQ EQ GT: one crossing, pulse for exactly one cycle
        do_reset("rst_a");
        smp(0, "s32_lt"); smp(1, "s32_eq1"); smp(1, "s32_eq2"); smp(2, "s32_gt");
        check("s32.cross_up", 32'(cross_up), 32'd1);
        check("s32.cross_count", 32'(cross_count), 32'd1);
        check("s32.lt", 32'(lt_count), 32'd1);
        check("s32.eq", 32'(eq_count), 32'd2);
        check("s32.gt", 32'(gt_count), 32'd1);
        step(0, 1, 1, 1, 0, "s32_after");
        check("s32.pulse_end", 32'(cross_up), 32'd0);

        // Direct LT->GT is not a crossing; later LT EQ LT EQ GT is
        do_reset("rst_b");
        smp(0, "s33_a"); smp(2, "s33_b");
        check("s33.no_direct", 32'(cross_up), 32'd0);
        smp(0, "s33_c"); smp(1, "s33_d"); smp(0, "s33_e"); smp(1, "s33_f"); smp(2, "s33_g");
        check("s33.cross_up", 32'(cross_up), 32'd1);
        check("s33.cross_count", 32'(cross_count), 32'd1);
        check("s33.lt", 32'(lt_count), 32'd3);
        check("s33.eq", 32'(eq_count), 32'd2);
        check("s33.gt", 32'(gt_count), 32'd2);

        // Back-to-back crossings
        smp(0, "b2b_1"); smp(1, "b2b_2"); smp(2, "b2b_3");
        smp(0, "b2b_4"); smp(1, "b2b_5"); smp(2, "b2b_6");
        check("b2b.cross_count", 32'(cross_count), 32'd3);

        // Saturation
        do_reset("rst_c");
        for (int i = 0; i < 300; i++) smp(1, "sat_eq");
        check("s34.eq", 32'(eq_count), 32'd255);
        check("s34.gt", 32'(gt_count), 32'd0);
        check("s34.lt", 32'(lt_count), 32'd0);

        // Non-one-hot sample in the middle of a would-be crossing
        do_reset("rst_d");
        smp(0, "s35_a"); smp(3, "s35_b"); smp(1, "s35_c"); smp(2, "s35_d");
        check("s35.cross_up", 32'(cross_up), 32'd0);
        check("s35.lt", 32'(lt_count), 32'd1);
        check("s35.eq", 32'(eq_count), 32'd1);
`ifdef COMPARATOR_MONITOR_ONEHOT_CHECK_EN
        check("s35.err", 32'(onehot_err), 32'd1);
        check("s35.gt", 32'(gt_count), 32'd1);
`else
        check("s35.err", 32'(onehot_err), 32'd0);
        check("s35.gt", 32'(gt_count), 32'd2);
`endif

        // Clear overrides a completing GT, FSM back to IDLE
        do_reset("rst_e");
        smp(0, "s36_a"); smp(1, "s36_b");
        step(1, 1, 0, 0, 1, "s36_clr");
        check("s36.cross_up", 32'(cross_up), 32'd0);
        check("s36.gt", 32'(gt_count), 32'd0);
        smp(1, "s36_c"); smp(2, "s36_d");
        check("s36.idle", 32'(cross_up), 32'd0);

        // Reset mid-sequence discards the partial crossing
        smp(0, "s25_a"); smp(1, "s25_b");
        do_reset("rst_mid");
        smp(2, "s25_c");
        check("s25.no_cross", 32'(cross_up), 32'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            f   = $urandom_range(0, 9);
            g = 0; e = 0; l = 0;
            if (f < 3)      l = 1;
            else if (f < 6) e = 1;
            else if (f < 8) g = 1;
            else begin
                g = 1'($urandom_range(0, 1));
                e = 1'($urandom_range(0, 1));
                l = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 199) == 0)
                do_reset("rnd_rst");
            else
                step(en, g, e, l, clr, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
